// File: rtl/alu_drv_pkg.sv
// Types and default parameters shared by the ALU stimulus driver and its response FIFO.
package alu_drv_pkg;
  localparam int unsigned RSP_DEPTH_DEF = 4;
  localparam int unsigned MAX_LAT_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2,
    ERROR = 2'd3
  } drv_state_e;

  typedef struct packed {
    logic [3:0] alu;
    logic       carry;
    logic       zero;
  } alu_rsp_t;
endpackage

// File: rtl/macro_pkg.sv
// Shared ALU opcode encoding used by the ALU, its monitor and this driver.
package macro_pkg;
  typedef enum logic [3:0] {
    ADD = 4'h0,
    SUB = 4'h1,
    AND = 4'h2,
    OR  = 4'h3,
    XOR = 4'h4
  } opcode_e;
endpackage

// File: rtl/alu_stim_driver_if.sv
// Request, ALU operand/result and response bundle of the ALU stimulus driver.
interface alu_stim_driver_if;
  import macro_pkg::*;

  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic       req_cin;
  opcode_e    req_ctl;

  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  opcode_e    ctl;
  logic       valid_in;
  logic       valid_out;
  logic [3:0] alu;
  logic       carry;
  logic       zero;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_alu;
  logic       rsp_carry;
  logic       rsp_zero;

  modport master (
    input  req_valid, req_a, req_b, req_cin, req_ctl,
    output req_ready,
    output a, b, cin, ctl, valid_in,
    input  valid_out, alu, carry, zero,
    output rsp_valid, rsp_alu, rsp_carry, rsp_zero,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_a, req_b, req_cin, req_ctl,
    input  req_ready,
    input  a, b, cin, ctl, valid_in,
    output valid_out, alu, carry, zero,
    input  rsp_valid, rsp_alu, rsp_carry, rsp_zero,
    output rsp_ready
  );
endinterface

// File: rtl/alu_rsp_fifo.sv
// Power-of-two response FIFO; the head is presented combinationally and reads as zero when empty.
module alu_rsp_fifo
  import alu_drv_pkg::*;
#(
  parameter int unsigned DEPTH = RSP_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  alu_rsp_t               i_data,
  input  logic                   i_pop,
  output alu_rsp_t               o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  alu_rsp_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_rd_en = i_pop && !o_empty;
  // A full FIFO still accepts a write in the cycle its head is popped.
  assign w_wr_en = i_push && (!o_full || w_rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_wr_en) - (PTR_W+1)'(w_rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/alu_stim_driver.sv
// Credit-based ALU issue engine with in-order response FIFO.
// ALU_DRV_TIMEOUT_EN adds a result-latency watchdog that locks the driver into ERROR.
//
// state | meaning
// IDLE  | credit available, no op accepted last cycle
// ISSUE | op accepted last cycle, more may follow back to back
// STALL | outstanding + queued responses fill the FIFO, requests held off
// ERROR | result timeout seen, requests refused until reset
module alu_stim_driver
  import alu_drv_pkg::*;
  import macro_pkg::*;
#(
  parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF,
  parameter int unsigned MAX_LAT   = MAX_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  alu_stim_driver_if.master          bus,
  output logic [$clog2(RSP_DEPTH):0] outstanding,
  output logic                       err_spurious,
  output logic                       err_timeout
);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;

  drv_state_e       r_state;
  drv_state_e       w_state_nxt;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic             r_cin;
  opcode_e          r_ctl;
  logic             r_valid_in;
  logic             r_req_ready;
  logic [CNT_W-1:0] r_outstanding;
  logic             r_err_spurious;

  logic [CNT_W-1:0] w_out_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_fifo_count;
  logic [CNT_W:0]   w_used_nxt;
  logic             w_accept;
  logic             w_spurious;
  logic             w_push;
  logic             w_pop;
  logic             w_credit_nxt;
  logic             w_timeout_hit;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_unused_full;
  alu_rsp_t         w_rsp_in;
  alu_rsp_t         w_rsp_head;

  assign w_accept   = bus.req_valid && r_req_ready;
  assign w_spurious = bus.valid_out && (r_outstanding == '0);
  assign w_push     = bus.valid_out && !w_spurious;
  assign w_pop      = !w_fifo_empty && bus.rsp_ready;
  assign w_rsp_in   = {bus.alu, bus.carry, bus.zero};

  // Credit is evaluated on next-cycle occupancy so req_ready can be a plain flop.
  assign w_out_nxt    = r_outstanding + CNT_W'(w_accept) - CNT_W'(w_push);
  assign w_cnt_nxt    = w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_used_nxt   = {1'b0, w_out_nxt} + {1'b0, w_cnt_nxt};
  assign w_credit_nxt = (w_used_nxt < (CNT_W+1)'(RSP_DEPTH));

  alu_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  (w_rsp_in),
    .i_pop   (w_pop),
    .o_data  (w_rsp_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );
  assign w_unused_full = w_fifo_full;

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ERROR || w_timeout_hit) begin
      w_state_nxt = ERROR;
    end else if (!w_credit_nxt) begin
      w_state_nxt = STALL;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = ISSUE;
        ISSUE:   if (!w_accept) w_state_nxt = IDLE;
        STALL:   w_state_nxt = IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_req_ready    <= 1'b0;
      r_valid_in     <= 1'b0;
      r_a            <= '0;
      r_b            <= '0;
      r_cin          <= 1'b0;
      r_ctl          <= ADD;
      r_outstanding  <= '0;
      r_err_spurious <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_req_ready   <= w_credit_nxt && (w_state_nxt != ERROR);
      r_valid_in    <= w_accept;
      r_outstanding <= w_out_nxt;
      if (w_accept) begin
        r_a   <= bus.req_a;
        r_b   <= bus.req_b;
        r_cin <= bus.req_cin;
        r_ctl <= bus.req_ctl;
      end
      if (w_spurious) r_err_spurious <= 1'b1;
    end
  end

`ifdef ALU_DRV_TIMEOUT_EN
  localparam int unsigned AGE_W = $clog2(MAX_LAT + 1);

  logic [AGE_W-1:0] r_age;
  logic             r_err_timeout;
  logic             w_age_reload;

  // Down-counter from MAX_LAT-1: terminal count on the MAX_LAT-th edge without progress.
  assign w_age_reload  = w_accept || w_push;
  assign w_timeout_hit = (r_outstanding != '0) && !w_age_reload && (r_age == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_age         <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_age_reload) r_age <= AGE_W'(MAX_LAT - 1);
      else if ((r_outstanding != '0) && (r_age != '0)) r_age <= r_age - AGE_W'(1);
      if (w_timeout_hit) r_err_timeout <= 1'b1;
    end
  end
  assign err_timeout = r_err_timeout;
`else
  logic w_unused_lat;
  assign w_unused_lat  = (MAX_LAT != 0);
  assign w_timeout_hit = 1'b0;
  assign err_timeout   = 1'b0;
`endif

  assign bus.req_ready = r_req_ready;
  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.cin       = r_cin;
  assign bus.ctl       = r_ctl;
  assign bus.valid_in  = r_valid_in;
  assign bus.rsp_valid = !w_fifo_empty;
  assign bus.rsp_alu   = w_rsp_head.alu;
  assign bus.rsp_carry = w_rsp_head.carry;
  assign bus.rsp_zero  = w_rsp_head.zero;
  assign outstanding   = r_outstanding;
  assign err_spurious  = r_err_spurious;
endmodule

// File: tb/tb_alu_stim_driver.sv
// Bench for alu_stim_driver: behavioural ALU responder, credit/order scoreboard, directed and random phases.
module tb_alu_stim_driver;
  import alu_drv_pkg::*;
  import macro_pkg::*;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [2:0] outstanding;
  logic       err_spurious;
  logic       err_timeout;

  alu_stim_driver_if bus();

  alu_stim_driver #(.RSP_DEPTH(DEPTH), .MAX_LAT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.master),
    .outstanding  (outstanding),
    .err_spurious (err_spurious),
    .err_timeout  (err_timeout)
  );

  int         total = 0;
  int         bad = 0;
  int         mout = 0;
  int         mfifo = 0;
  int         n_acc = 0;
  int         lat = 1;
  bit         check_en = 0;
  bit         suppress = 0;
  bit         inject = 0;
  bit         m_spur = 0;
  bit         p_acc = 0;
  logic [3:0] ea = '0;
  logic [3:0] eb = '0;
  logic       ecin = 1'b0;
  opcode_e    ectl = ADD;
  logic [5:0] exp_q[$];
  logic [5:0] pipe_d[8];
  bit         pipe_v[8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU: {result, carry, zero}
  function automatic logic [5:0] alu_f(input opcode_e op, input logic [3:0] x, input logic [3:0] y,
                                       input logic ci);
    logic [4:0] s;
    case (op)
      ADD:     s = {1'b0, x} + {1'b0, y} + {4'b0, ci};
      SUB:     s = {1'b0, x} - {1'b0, y};
      AND:     s = {1'b0, x & y};
      OR:      s = {1'b0, x | y};
      XOR:     s = {1'b0, x ^ y};
      default: s = '0;
    endcase
    return {s[3:0], s[4], (s[3:0] == 4'h0)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req();
    bus.req_a   = 4'($urandom_range(0, 15));
    bus.req_b   = 4'($urandom_range(0, 15));
    bus.req_cin = 1'($urandom_range(0, 1));
    bus.req_ctl = opcode_e'($urandom_range(0, 4));
  endtask

  task automatic send(input logic [3:0] x, input logic [3:0] y, input logic ci, input opcode_e op);
    bit ok;
    ok = 0;
    bus.req_a = x; bus.req_b = y; bus.req_cin = ci; bus.req_ctl = op;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #2;
      ok = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    if (!ok) chk("send_accept", 0, 1);
  endtask

  // Hold req_valid high for ncyc cycles, presenting a fresh request after each accept.
  task automatic stream(input int ncyc);
    bit acc;
    bus.req_valid = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk); #2;
      acc = bus.req_ready;
      tick();
      if (acc) rand_req();
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      ok = (mout == 0) && (mfifo == 0) && !bus.rsp_valid && (exp_q.size() == 0);
    end
    chk("drain", ok, 1);
  endtask

  // ALU responder with configurable latency; results ride a shift pipe.
  initial begin
    for (int i = 0; i < 8; i++) begin pipe_v[i] = 0; pipe_d[i] = '0; end
    bus.valid_out = 1'b0; bus.alu = '0; bus.carry = 1'b0; bus.zero = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 7; i > 0; i--) begin pipe_v[i] = pipe_v[i-1]; pipe_d[i] = pipe_d[i-1]; end
      pipe_v[0] = bus.valid_in;
      pipe_d[0] = alu_f(bus.ctl, bus.a, bus.b, bus.cin);
      if (inject) begin
        bus.valid_out = 1'b1;
        {bus.alu, bus.carry, bus.zero} = 6'h3F;
      end else begin
        bus.valid_out = pipe_v[lat] && !suppress;
        {bus.alu, bus.carry, bus.zero} = pipe_d[lat];
      end
    end
  end

  // Every-cycle comparison against the credit/ordering model.
  initial begin
    bit w_acc, w_push, w_pop;
    forever begin
      @(negedge clk); #2;
      if (check_en) begin
        chk("outstanding", int'(outstanding), mout);
        chk("rsp_valid", int'(bus.rsp_valid), int'(mfifo > 0));
        chk("req_ready", int'(bus.req_ready), int'((mout + mfifo) < DEPTH));
        chk("err_spurious", int'(err_spurious), int'(m_spur));
        chk("err_timeout", int'(err_timeout), 0);
        chk("valid_in", int'(bus.valid_in), int'(p_acc));
        chk("operands", int'({bus.a, bus.b, bus.cin, bus.ctl}), int'({ea, eb, ecin, ectl}));
        w_acc  = bus.req_valid && bus.req_ready;
        w_push = bus.valid_out && (mout > 0);
        w_pop  = bus.rsp_valid && bus.rsp_ready;
        if (bus.valid_out && mout == 0) m_spur = 1;
        if (w_pop) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else chk("rsp_data", int'({bus.rsp_alu, bus.rsp_carry, bus.rsp_zero}), int'(exp_q.pop_front()));
        end
        if (w_acc) begin
          exp_q.push_back(alu_f(bus.req_ctl, bus.req_a, bus.req_b, bus.req_cin));
          ea = bus.req_a; eb = bus.req_b; ecin = bus.req_cin; ectl = bus.req_ctl;
          n_acc++;
        end
        p_acc = w_acc;
        mout  = mout + int'(w_acc) - int'(w_push);
        mfifo = mfifo + int'(w_push) - int'(w_pop);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc0, sent, cyc;
    bit acc, ok;

    chk("model_add", int'(alu_f(ADD, 4'h7, 4'h9, 1'b1)), 6'h06);
    chk("model_sub_zero", int'(alu_f(SUB, 4'h5, 4'h5, 1'b0)), 6'h01);
    chk("model_sub_borrow", int'(alu_f(SUB, 4'h3, 4'h5, 1'b0)), 6'h3A);

    reset = 1'b0;
    bus.rsp_ready = 1'b0;
    rand_req();
    bus.req_valid = 1'b1;
    repeat (3) tick();
    chk("rst_valid_in", int'(bus.valid_in), 0);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_outstanding", int'(outstanding), 0);
    chk("rst_err_spurious", int'(err_spurious), 0);
    chk("rst_ctl", int'(bus.ctl), 0);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("post_rst_req_ready", int'(bus.req_ready), 1);
    check_en = 1;

    // Single ADD, 1-cycle ALU latency
    send(4'h7, 4'h9, 1'b1, ADD);
    chk("single_valid_in", int'(bus.valid_in), 1);
    chk("single_operands", int'({bus.a, bus.b, bus.cin, bus.ctl}), int'({4'h7, 4'h9, 1'b1, ADD}));
    tick();
    chk("single_valid_in_drop", int'(bus.valid_in), 0);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (bus.rsp_valid) ok = 1; else tick();
    end
    chk("single_rsp_wait", ok, 1);
    chk("single_rsp", int'({bus.rsp_alu, bus.rsp_carry, bus.rsp_zero}), 6'h06);
    chk("single_outstanding", int'(outstanding), 0);
    drain();

    // Credit exhaustion
    bus.rsp_ready = 1'b0;
    acc0 = n_acc;
    rand_req();
    stream(6);
    repeat (3) stream(1);
    chk("credit_accepts", n_acc - acc0, 4);
    chk("credit_req_ready", int'(bus.req_ready), 0);
    chk("credit_state", int'(dut.r_state), int'(STALL));
    chk("credit_outstanding", int'(outstanding), 0);
    bus.rsp_ready = 1'b1;
    stream(1);
    bus.rsp_ready = 1'b0;
    stream(5);
    chk("credit_readmit", n_acc - acc0, 5);
    drain();

    // Random traffic, 2-cycle ALU latency
    lat = 2;
    sent = 0;
    cyc = 0;
    bus.req_valid = 1'b0;
    while (sent < 20 && cyc < 2000) begin
      if (!bus.req_valid && $urandom_range(0, 3) != 0) begin
        rand_req();
        bus.req_valid = 1'b1;
      end
      bus.rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk); #2;
      acc = bus.req_valid && bus.req_ready;
      tick();
      cyc++;
      if (acc) begin sent++; bus.req_valid = 1'b0; end
    end
    chk("random_sent", sent, 20);
    drain();
    lat = 1;

    // Spurious result with one response parked in the FIFO
    bus.rsp_ready = 1'b0;
    send(4'h3, 4'h5, 1'b0, SUB);
    repeat (4) tick();
    chk("spur_before", int'(err_spurious), 0);
    inject = 1;
    tick();
    inject = 0;
    repeat (2) tick();
    chk("spur_flag", int'(err_spurious), 1);
    chk("spur_outstanding", int'(outstanding), 0);
    chk("spur_rsp_valid", int'(bus.rsp_valid), 1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    tick();
    chk("spur_fifo_single", int'(bus.rsp_valid), 0);
    repeat (3) tick();
    chk("spur_sticky", int'(err_spurious), 1);
    drain();

`ifdef ALU_DRV_TIMEOUT_EN
    begin
      int hit;
      check_en = 0;
      suppress = 1;
      hit = -1;
      send(4'h1, 4'h2, 1'b0, ADD);
      for (int i = 1; i <= 12; i++) begin
        tick();
        if (err_timeout && hit < 0) hit = i;
      end
      chk("timeout_cycle", hit, 8);
      bus.req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick();
        chk("timeout_req_ready", int'(bus.req_ready), 0);
        chk("timeout_no_issue", int'(bus.valid_in), 0);
      end
      chk("timeout_sticky", int'(err_timeout), 1);
      bus.req_valid = 1'b0;
      reset = 1'b0;
      tick();
      chk("timeout_reset_clear", int'(err_timeout), 0);
      reset = 1'b1;
      suppress = 0;
      tick();
      chk("timeout_post_reset_ready", int'(bus.req_ready), 1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
